// File: rtl/gate_arb_pkg.sv
// Shared types and constants for the gate arbiter.
//   op_t    : 3-bit bitwise opcode
//   state_t : arbiter FSM state
//   CNT_W   : width of the optional per-requester grant counters
package gate_arb_pkg;

  localparam int unsigned OP_W  = 3;
  localparam int unsigned REQ_N = 2;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [OP_W-1:0] {
    OP_NOTA = 3'd0,
    OP_NOTB = 3'd1,
    OP_OR   = 3'd2,
    OP_AND  = 3'd3,
    OP_XOR  = 3'd4,
    OP_NOR  = 3'd5,
    OP_NAND = 3'd6,
    OP_XNOR = 3'd7
  } op_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_t;

endpackage

// File: rtl/gate_arbiter_if.sv
// Request/result bundle between two requesters, a result consumer and the arbiter.
//   req[1:0], op0/op1, a0/b0/a1/b1 : requester side
//   gnt[1:0]                       : combinational one-hot grant
//   res, res_valid, res_id         : registered result
//   res_ready                      : consumer acceptance
// master = requesters/consumer, slave = arbiter.
interface gate_arbiter_if
  import gate_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 4
);

  logic [REQ_N-1:0] req;
  logic [OP_W-1:0]  op0;
  logic [OP_W-1:0]  op1;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic [REQ_N-1:0] gnt;
  logic [WIDTH-1:0] res;
  logic             res_valid;
  logic             res_id;
  logic             res_ready;

  modport master (
    output req, op0, op1, a0, b0, a1, b1, res_ready,
    input  gnt, res, res_valid, res_id
  );

  modport slave (
    input  req, op0, op1, a0, b0, a1, b1, res_ready,
    output gnt, res, res_valid, res_id
  );

endinterface

// File: rtl/gate_lane_alu.sv
// Combinational bitwise gate evaluation of one operand pair.
//   op : opcode, a/b : operands, y : WIDTH-bit result (no extension)
module gate_lane_alu
  import gate_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_NOTA: y = ~a;
      OP_NOTB: y = ~b;
      OP_OR:   y = a | b;
      OP_AND:  y = a & b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      OP_NAND: y = ~(a & b);
      OP_XNOR: y = ~(a ^ b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/gate_arbiter.sv
// Two-requester round-robin arbiter feeding a shared bitwise gate unit.
//   clk, rst : clock, synchronous active-high reset
//   bus      : gate_arbiter_if slave (req/op/operands in, gnt/res/res_valid/res_id out,
//              res_ready in)
//   gnt_cnt0/gnt_cnt1 : saturating grant counters, present only with GATE_ARB_STATS_EN
module gate_arbiter
  import gate_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  gate_arbiter_if.slave      bus
`ifdef GATE_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]   gnt_cnt0,
  output logic [CNT_W-1:0]   gnt_cnt1
`endif
);

  state_t           state;
  logic             last_win;
  logic             win_id;
  logic [OP_W-1:0]  op_sel;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic [WIDTH-1:0] alu_y;

  // Grant decode: only in IDLE and out of reset; contention goes to the
  // requester that did not win last.
  always_comb begin
    bus.gnt = '0;
    if (!rst && state == S_IDLE) begin
      case (bus.req)
        2'b01:   bus.gnt = 2'b01;
        2'b10:   bus.gnt = 2'b10;
        2'b11:   bus.gnt = last_win ? 2'b01 : 2'b10;
        default: bus.gnt = '0;
      endcase
    end
  end

  assign win_id = bus.gnt[1];

  // Operand mux ahead of the single shared ALU.
  always_comb begin
    op_sel = bus.op0;
    a_sel  = bus.a0;
    b_sel  = bus.b0;
    if (win_id) begin
      op_sel = bus.op1;
      a_sel  = bus.a1;
      b_sel  = bus.b1;
    end
  end

  gate_lane_alu #(.WIDTH(WIDTH)) u_alu (
    .op (op_t'(op_sel)),
    .a  (a_sel),
    .b  (b_sel),
    .y  (alu_y)
  );

  // Arbiter FSM with registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      bus.res       <= '0;
      bus.res_valid <= 1'b0;
      bus.res_id    <= 1'b0;
      last_win      <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (|bus.gnt) begin
            bus.res       <= alu_y;
            bus.res_id    <= win_id;
            bus.res_valid <= 1'b1;
            last_win      <= win_id;
            state         <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef GATE_ARB_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Saturating per-requester grant counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      if (bus.gnt[0] && gnt_cnt0 != CNT_MAX) gnt_cnt0 <= gnt_cnt0 + CNT_W'(1);
      if (bus.gnt[1] && gnt_cnt1 != CNT_MAX) gnt_cnt1 <= gnt_cnt1 + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_gate_arbiter.sv
// Self-checking bench for gate_arbiter: directed scenarios followed by random
// traffic, all compared against a cycle-level reference model kept here.
module tb_gate_arbiter;

  localparam int unsigned W = 4;

  logic clk;
  logic rst;

  gate_arbiter_if #(.WIDTH(W)) bus ();

`ifdef GATE_ARB_STATS_EN
  logic [7:0] gnt_cnt0;
  logic [7:0] gnt_cnt1;
`endif

  gate_arbiter #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef GATE_ARB_STATS_EN
    ,
    .gnt_cnt0 (gnt_cnt0),
    .gnt_cnt1 (gnt_cnt1)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks;
  int failures;

  // Reference model state
  logic         m_busy;
  logic [W-1:0] m_res;
  logic         m_id;
  logic         m_last;
  logic [1:0]   obs_gnt;
  logic [1:0]   exp_gnt;

  // Truth table per opcode, indexed by {a_bit, b_bit}.
  logic [3:0] tt [8];
  logic [3:0] sweep_exp [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] eval_ref(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    logic [3:0]   t;
    logic [W-1:0] r;
    t = tt[op];
    for (int i = 0; i < int'(W); i++) r[i] = t[{a[i], b[i]}];
    return r;
  endfunction

  // One clock: inputs already driven at the preceding negedge.
  task automatic cycle(input logic rs, input logic rdy);
    logic idx;
    bus.res_ready = rdy;
    rst = rs;
    #1;
    if (rs || m_busy) exp_gnt = 2'b00;
    else begin
      case (bus.req)
        2'b01:   exp_gnt = 2'b01;
        2'b10:   exp_gnt = 2'b10;
        2'b11:   exp_gnt = m_last ? 2'b01 : 2'b10;
        default: exp_gnt = 2'b00;
      endcase
    end
    obs_gnt = bus.gnt;
    chk("gnt", 32'(bus.gnt), 32'(exp_gnt));
    @(posedge clk);
    #1;
    if (rs) begin
      m_busy = 1'b0; m_res = '0; m_id = 1'b0; m_last = 1'b1;
    end else if (m_busy) begin
      if (rdy) m_busy = 1'b0;
    end else if (exp_gnt != 2'b00) begin
      idx    = exp_gnt[1];
      m_res  = idx ? eval_ref(bus.op1, bus.a1, bus.b1) : eval_ref(bus.op0, bus.a0, bus.b0);
      m_id   = idx;
      m_busy = 1'b1;
      m_last = idx;
    end
    chk("res_valid", 32'(bus.res_valid), 32'(m_busy));
    chk("res", 32'(bus.res), 32'(m_res));
    chk("res_id", 32'(bus.res_id), 32'(m_id));
    @(negedge clk);
  endtask

  logic [W-1:0] held_res;
  logic [1:0]   rnd_req;

  initial begin
    checks   = 0;
    failures = 0;
    tt        = '{4'h3, 4'h5, 4'hE, 4'h8, 4'h6, 4'h1, 4'h7, 4'h9};
    sweep_exp = '{4'b0011, 4'b0101, 4'b1110, 4'b1000, 4'b0110, 4'b0001, 4'b0111, 4'b1001};
    m_busy = 1'b0; m_res = '0; m_id = 1'b0; m_last = 1'b1;
    rst = 1'b1;
    bus.req = 2'b11; bus.res_ready = 1'b0;
    bus.op0 = '0; bus.op1 = '0;
    bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
    @(negedge clk);

    // Reset: gnt held low even with both requests up.
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    chk("rst_gnt", 32'(obs_gnt), 32'd0);

    // Single request, AND.
    bus.req = 2'b01; bus.op0 = 3'd3; bus.a0 = 4'b1100; bus.b0 = 4'b1010;
    cycle(1'b0, 1'b1);
    chk("single_gnt", 32'(obs_gnt), 32'b01);
    chk("single_res", 32'(bus.res), 32'b1000);
    bus.req = 2'b00;
    cycle(1'b0, 1'b1);

    // Opcode sweep on requester 0.
    for (int op = 0; op < 8; op++) begin
      bus.req = 2'b01; bus.op0 = 3'(op);
      cycle(1'b0, 1'b1);
      chk("sweep_res", 32'(bus.res), 32'(sweep_exp[op]));
      bus.req = 2'b00;
      cycle(1'b0, 1'b1);
    end

    // Contention with req=11 held continuously.
    bus.req = 2'b00;
    cycle(1'b1, 1'b1);
    bus.req = 2'b11;
    bus.op1 = 3'd2; bus.a1 = 4'b0011; bus.b1 = 4'b0100;
    for (int k = 0; k < 8; k++) begin
      cycle(1'b0, 1'b1);
      if (k % 2 == 0) begin
        chk("cont_gnt", 32'(obs_gnt), ((k / 2) % 2 == 0) ? 32'b01 : 32'b10);
        chk("cont_id", 32'(bus.res_id), 32'((k / 2) % 2));
      end else begin
        chk("cont_gap", 32'(obs_gnt), 32'd0);
      end
    end

    // Backpressure with requester 1 waiting.
    bus.req = 2'b00;
    cycle(1'b1, 1'b1);
    bus.req = 2'b01; bus.op0 = 3'd4; bus.a0 = 4'b1001; bus.b0 = 4'b0101;
    cycle(1'b0, 1'b0);
    held_res = bus.res;
    bus.req = 2'b10;
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 1'b0);
      chk("bp_gnt", 32'(obs_gnt), 32'd0);
      chk("bp_res", 32'(bus.res), 32'(held_res));
    end
    cycle(1'b0, 1'b1);
    chk("bp_release_gnt", 32'(obs_gnt), 32'd0);
    cycle(1'b0, 1'b1);
    chk("bp_req1_gnt", 32'(obs_gnt), 32'b10);

    // Reset while a result is pending.
    bus.req = 2'b00;
    cycle(1'b1, 1'b1);
    chk("rst_mid_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_mid_res", 32'(bus.res), 32'd0);
    bus.req = 2'b11;
    cycle(1'b0, 1'b1);
    chk("rst_mid_gnt", 32'(obs_gnt), 32'b01);
    bus.req = 2'b00;
    cycle(1'b0, 1'b1);

    // Random traffic; requests held until granted, then dropped.
    rnd_req = 2'b00;
    for (int n = 0; n < 600; n++) begin
      if (obs_gnt[0]) rnd_req[0] = 1'b0;
      if (obs_gnt[1]) rnd_req[1] = 1'b0;
      if (!rnd_req[0] && $urandom_range(0, 2) == 0) begin
        rnd_req[0] = 1'b1;
        bus.op0 = 3'($urandom); bus.a0 = W'($urandom); bus.b0 = W'($urandom);
      end
      if (!rnd_req[1] && $urandom_range(0, 2) == 0) begin
        rnd_req[1] = 1'b1;
        bus.op1 = 3'($urandom); bus.a1 = W'($urandom); bus.b1 = W'($urandom);
      end
      bus.req = rnd_req;
      cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0));
    end

`ifdef GATE_ARB_STATS_EN
    // Counter saturation after 300 grants to requester 0.
    bus.req = 2'b00;
    cycle(1'b1, 1'b1);
    for (int n = 0; n < 300; n++) begin
      bus.req = 2'b01;
      cycle(1'b0, 1'b1);
      bus.req = 2'b00;
      cycle(1'b0, 1'b1);
    end
    chk("gnt_cnt0", 32'(gnt_cnt0), 32'd255);
    chk("gnt_cnt1", 32'(gnt_cnt1), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gate_arbiter.md
GATE_ARBITER -- requirements
Module: gate_arbiter

Interface
REQ-001 Parameter WIDTH, default 4, sets the operand and result width in bits.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req  input  2  per-requester request, bit i = requester i; held high until granted.
REQ-005 op0, op1  input  3 each  per-requester opcode.
REQ-006 a0, b0, a1, b1  input  WIDTH each  per-requester operands.
REQ-007 gnt  output  2  one-hot grant, combinational; at most one bit high.
REQ-008 res  output  WIDTH  registered result.
REQ-009 res_valid  output  1  result valid.
REQ-010 res_id  output  1  index of the requester that owns res.
REQ-011 res_ready  input  1  consumer accepts res when high with res_valid.

Function
REQ-012 Opcodes are decoded bitwise over WIDTH:
- 0 = ~a
- 1 = ~b
- 2 = a|b
- 3 = a&b
- 4 = a^b
- 5 = ~(a|b)
- 6 = ~(a&b)
- 7 = ~(a^b)
REQ-013 The FSM has two states: IDLE and RESP.
REQ-014 In IDLE with req != 0, gnt SHALL select a winner in the same cycle.
REQ-015 At the next edge, the winner's op/a/b SHALL be evaluated, res/res_id registered, res_valid set to 1, and state set to RESP.
REQ-016 In RESP, gnt SHALL be 2'b00 and requests SHALL be ignored.
REQ-017 In RESP, res, res_id and res_valid SHALL hold until an edge with res_ready=1; at that edge res_valid clears and state returns to IDLE.
REQ-018 Latency: grant cycle N gives res_valid at N+1. Minimum issue interval is 2 cycles when res_ready is tied high.
REQ-019 A single requester SHALL be granted directly.
REQ-020 When req=2'b11, grant SHALL go to the requester not granted most recently (round-robin). The last-winner register updates only on a grant.
REQ-021 A requester SHALL drop req at the edge after seeing its gnt bit. Re-asserting req is a new request.
REQ-022 res_ready while res_valid=0 SHALL have no effect.
REQ-023 res SHALL be exactly WIDTH bits, with no sign or width extension.

Reset
REQ-024 rst=1 at an edge SHALL force:
- state = IDLE
- res = 0
- res_valid = 0
- res_id = 0
- last-winner = 1, so requester 0 wins the first contention
REQ-025 rst asserted during RESP SHALL discard the pending result without handshake.
REQ-026 gnt SHALL be 2'b00 in any cycle in which rst=1.

Configuration
REQ-027 With macro GATE_ARB_STATS_EN defined, the block SHALL add:
- outputs gnt_cnt0 and gnt_cnt1, 8 bits each
- each counter increments per grant to its requester
- counters saturate at 255 and reset to 0
REQ-028 Without GATE_ARB_STATS_EN, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-029 Package gate_arb_pkg SHALL hold:
- the 3-bit opcode enum (OP_NOTA, OP_NOTB, OP_OR, OP_AND, OP_XOR, OP_NOR, OP_NAND, OP_XNOR)
- the FSM state typedef
- the counter-width constant
REQ-030 Opcode evaluation SHALL live in one combinational sub-module, gate_lane_alu (inputs op, a, b; output y), instantiated once after the grant mux.

Verification
REQ-031 Single request, WIDTH=4, res_ready=1:
- stimulus: req=01, op0=3, a0=4'b1100, b0=4'b1010
- response: gnt=01 for one cycle; next cycle res=4'b1000, res_id=0, res_valid=1
REQ-032 Opcode sweep:
- stimulus: a=4'b1100, b=4'b1010, ops 0..7
- response: res = 0011, 0101, 1110, 1000, 0110, 0001, 0111, 1001
REQ-033 Contention:
- stimulus: req=11 held continuously after reset, res_ready=1
- response: grants alternate 01, 10, 01, 10; res_id alternates 0, 1, 0, 1
REQ-034 Backpressure:
- stimulus: res_ready=0 for 5 cycles after res_valid, with req1 pending
- response: res stable, gnt=00 throughout; req1 granted the cycle after the res_ready=1 edge
REQ-035 Reset mid-operation:
- stimulus: rst=1 during RESP
- response: next cycle res_valid=0, res=0; a subsequent req=11 grants requester 0
REQ-036 With GATE_ARB_STATS_EN defined:
- stimulus: 300 grants to requester 0
- response: gnt_cnt0=255, gnt_cnt1=0
